// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with standard/FWFT read, occupancy count, threshold flags,
// overflow/underflow pulses and synchronous flush.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 128,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DATA_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [$clog2(DATA_DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int AW = $clog2(DATA_DEPTH);

    if (DATA_DEPTH < 2 || (DATA_DEPTH & (DATA_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DATA_DEPTH must be a power of two >= 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [AW:0]           r_count;
    logic                  r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic                  w_wr, w_rd;
    logic [AW:0]           w_next;

    assign w_wr   = wr_en & ~r_full;
    assign w_rd   = rd_en & ~r_empty;
    assign w_next = r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);

    always_ff @(posedge Clk)
        if (w_wr && !clr) r_mem[r_wptr] <= data_in;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn || clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_wr);
            r_rptr  <= r_rptr + AW'(w_rd);
            r_count <= w_next;
            r_full  <= w_next == (AW+1)'(DATA_DEPTH);
            r_empty <= w_next == '0;
            r_af    <= w_next >= (AW+1)'(AF_THRESH);
            r_ae    <= w_next <= (AW+1)'(AE_THRESH);
            r_ovf   <= wr_en & r_full;
            r_unf   <= rd_en & r_empty;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = r_empty ? '0 : r_mem[r_rptr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_dout;
        always_ff @(posedge Clk or negedge Resetn) begin
            if (!Resetn || clr) r_dout <= '0;
            else if (w_rd) r_dout <= r_mem[r_rptr];
        end
        assign data_out = r_dout;
    end

    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives a standard-mode DEPTH=4 FIFO and an FWFT DEPTH=8 FIFO from shared
// stimulus and compares every output each cycle against queue-based reference models.
module tb_sync_fifo;
    logic       Clk = 1'b0, Resetn = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] d0, d1;
    logic [2:0] c0;
    logic [3:0] c1;
    logic       f0, e0, af0, ae0, ov0, un0;
    logic       f1, e1, af1, ae1, ov1, un1;
    int         n_chk = 0, n_err = 0;
    logic [7:0] q0[$], q1[$];
    logic [7:0] sd0 = '0;
    logic       eo0 = 0, eu0 = 0, eo1 = 0, eu1 = 0;

    always #5 Clk = ~Clk;

    sync_fifo #(.DATA_WIDTH(8), .DATA_DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_std (
        .Clk(Clk), .Resetn(Resetn), .clr(clr), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(d0), .full(f0), .empty(e0), .almost_full(af0), .almost_empty(ae0),
        .count(c0), .overflow(ov0), .underflow(un0));

    sync_fifo #(.DATA_WIDTH(8), .DATA_DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_fwft (
        .Clk(Clk), .Resetn(Resetn), .clr(clr), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(d1), .full(f1), .empty(e1), .almost_full(af1), .almost_empty(ae1),
        .count(c1), .overflow(ov1), .underflow(un1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count0", 32'(c0), q0.size());
        chk("full0", 32'(f0), 32'(q0.size() == 4));
        chk("empty0", 32'(e0), 32'(q0.size() == 0));
        chk("afull0", 32'(af0), 32'(q0.size() >= 3));
        chk("aempty0", 32'(ae0), 32'(q0.size() <= 1));
        chk("ovf0", 32'(ov0), 32'(eo0));
        chk("unf0", 32'(un0), 32'(eu0));
        chk("dout0", 32'(d0), 32'(sd0));
        chk("count1", 32'(c1), q1.size());
        chk("full1", 32'(f1), 32'(q1.size() == 8));
        chk("empty1", 32'(e1), 32'(q1.size() == 0));
        chk("afull1", 32'(af1), 32'(q1.size() >= 6));
        chk("aempty1", 32'(ae1), 32'(q1.size() <= 2));
        chk("ovf1", 32'(ov1), 32'(eo1));
        chk("unf1", 32'(un1), 32'(eu1));
        chk("dout1", 32'(d1), 32'(q1.size() > 0 ? q1[0] : 8'h00));
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        sd0 = '0;
        {eo0, eu0, eo1, eu1} = '0;
    endtask

    // Apply the FIFO rules for the coming edge to the models, using pre-edge occupancy.
    task automatic model_edge();
        if (clr) model_clear();
        else begin
            eo0 = wr_en && q0.size() == 4;
            eu0 = rd_en && q0.size() == 0;
            eo1 = wr_en && q1.size() == 8;
            eu1 = rd_en && q1.size() == 0;
            if (rd_en && !eu0) sd0 = q0.pop_front();
            if (rd_en && !eu1) void'(q1.pop_front());
            if (wr_en && !eo0) q0.push_back(data_in);
            if (wr_en && !eo1) q1.push_back(data_in);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
        wr_en = w;
        rd_en = r;
        data_in = d;
        clr = c;
        model_edge();
        @(negedge Clk);
        check_all();
    endtask

    initial begin
        int pw, pr;
        repeat (2) @(negedge Clk);
        check_all();
        Resetn = 1'b1;
        @(negedge Clk);
        check_all();
        for (int i = 1; i <= 4; i++) step(1, 0, 8'(i * 8'h11), 0);
        step(1, 0, 8'h55, 0);
        step(0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h01, 0);
        step(1, 0, 8'h02, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 8'hA0 + 8'(i), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
        step(1, 1, 8'h3C, 0);
        step(0, 1, 8'h00, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 8'h70 + 8'(i), 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'hC0 + 8'(i), 0);
        step(1, 0, 8'hEE, 1);
        step(0, 0, 8'h00, 0);
        pw = 50;
        pr = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                pw = $urandom_range(90, 10);
                pr = $urandom_range(90, 10);
            end
            if (i == 1500) begin
                #2 Resetn = 1'b0;
                model_clear();
                #1 check_all();
                @(negedge Clk);
                check_all();
                Resetn = 1'b1;
            end
            step($urandom_range(99) < pw, $urandom_range(99) < pr, 8'($urandom), $urandom_range(99) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO for the UART datapath, used as TX holding buffer and RX receive buffer. Adds standard or first-word-fall-through read mode, an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow pulses and a synchronous flush. Sits between the AXI-Lite register interface and the UART TX/RX shift engines. Replaces the fixed single-mode FIFO in new instantiations.

## Interface

Parameters:
- DATA_WIDTH, 8, word width in bits (≥1).
- DATA_DEPTH, 128, entries; power of two, ≥2 (elaboration error otherwise).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_THRESH, DATA_DEPTH-1, almost_full asserts when count ≥ AF_THRESH (1..DATA_DEPTH).
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH (0..DATA_DEPTH-1).
- Derived: AW = $clog2(DATA_DEPTH).

Ports:
- Clk  in  1  single clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush.
- data_in  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (FWFT: pop/acknowledge of head word).
- data_out  out  DATA_WIDTH  read data.
- full, empty  out  1  count == DATA_DEPTH / count == 0.
- almost_full, almost_empty  out  1  threshold flags.
- count  out  AW+1  current occupancy, 0..DATA_DEPTH.
- overflow, underflow  out  1  one-cycle pulse on rejected write/read.

## Operation

- Storage: register array of DATA_DEPTH words. Read and write pointers are AW bits wide and wrap DATA_DEPTH-1 → 0 by natural overflow.
- Write accepted = wr_en & !full. An accepted write stores data_in at wptr and increments wptr.
- Read accepted = rd_en & !empty. An accepted read increments rptr.
- Acceptance uses the flags as they are before the edge:
  - When full, a write is rejected even with a simultaneous accepted read.
  - When empty, a read is rejected even with a simultaneous accepted write.
- count update per edge: +1 (write only), −1 (read only), unchanged (both or neither). Never exceeds DATA_DEPTH or goes below 0.
- full, empty, almost_full and almost_empty are registered and updated on the same edge as count, from the next count value.
- overflow = registered (wr_en & full). underflow = registered (rd_en & empty). Each lasts one cycle per offending cycle.
- Standard mode (FWFT=0): on an accepted read, data_out ← mem[rptr] (registered). Otherwise data_out holds its value.
- FWFT mode: data_out = mem[rptr] when !empty, else 0. rd_en pops the displayed word.
- clr (priority over wr_en/rd_en, below Resetn):
  - Pointers and count → 0; flags → reset values; standard-mode data_out → 0.
  - No overflow/underflow pulse that cycle.
  - Memory contents not cleared.
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0 (unless AF_THRESH=0, which is disallowed), overflow=0, underflow=0, data_out=0, pointers=0.
- Reset mid-operation discards all contents immediately; it does not wait for an edge.

## Timing

- Write at edge N: count, empty and flags reflect it after edge N.
  - FWFT: first word visible on data_out after edge N (write-to-read latency 1 cycle).
- Standard-mode read accepted at edge N: data_out valid after edge N, held until the next accepted read.
- Simultaneous accepted read and write at the same edge: count unchanged. With count=1, the read returns the old head word; the new word becomes the head.
- overflow/underflow assert after the edge at which the bad request was sampled, for exactly one cycle.
- No combinational path from wr_en/rd_en to any output. In FWFT, data_out depends only on registered state.

## Test plan

- Reset/fill/drain (DEPTH=4, FWFT=0):
  - After Resetn release: empty=1, count=0.
  - Write 0x11,0x22,0x33,0x44: count 1,2,3,4, full=1 after the 4th edge.
  - Read 4×: data_out 0x11..0x44, empty=1 after the 4th read.
- Overflow/underflow:
  - Full FIFO + wr_en with 0x55: overflow pulses 1 cycle, count stays 4, 0x55 never read.
  - Empty FIFO + rd_en: underflow pulses 1 cycle, data_out unchanged.
- Simultaneous read+write:
  - count=2, read+write 0xAA for 10 cycles: count stays 2, output order preserved, pointers wrap twice.
  - Empty FIFO with rd_en=wr_en=1: write accepted, underflow=1, count=1.
- FWFT (DEPTH=8):
  - Write 0x3C: data_out=0x3C and empty=0 after the same edge, with no rd_en.
  - rd_en pops it: data_out=0 and empty=1 after the next edge.
- Thresholds (DEPTH=8, AF=6, AE=2):
  - almost_empty drops when count goes 2→3.
  - almost_full rises when count goes 5→6; both track during drain.
- Flush/reset mid-op:
  - clr with count=5 and wr_en=1: count=0, empty=1 next cycle, write discarded.
  - Resetn pulse mid-burst: outputs take reset values asynchronously.
